uart_rx_frame: RTL and testbench
================================

# uart_rx_frame

Parametrised UART receiver: the successor to the fixed 8N1 receiver in the host-link path. It adds configurable data width, optional parity, one or two stop bits and 3-sample majority voting. It reports framing, parity and break conditions with every received character. It sits between the board RX pin and the command/pixel-stream parser, and hands over one registered character per `o_recvdata` strobe.

## Interface
Parameters:
- `TICKS_PER_BIT`, 32: `i_clk` cycles per bit period; must be ≥ 4.
- `TICKS_PER_BIT_SIZE`, 6: tick counter width; must hold `TICKS_PER_BIT`.
- `DATA_BITS`, 8: data bits per character, 5..9, LSB first on the line.
- `STOP_BITS`, 1: 1 or 2.
- `PARITY_MODE`, 0: 0 none, 1 odd, 2 even. Only honoured with `UART_RX_PARITY_EN`.
- `MAJORITY`, 1: 1 = 3-sample vote centred on the mid-bit; 0 = single mid-bit sample.

Ports:
- `i_clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `i_enable` in 1: arms start detection; gates only new frames.
- `i_din_priortobuffer` in 1: asynchronous serial input, idle high.
- `o_rxdata` out DATA_BITS: last received character, held until the next DONE.
- `o_recvdata` out 1: one-cycle strobe; `o_rxdata` and all error flags are valid in that cycle.
- `o_busy` out 1: high in every state except IDLE.
- `o_frame_err` out 1: at least one stop-bit sample was low; held until the next DONE.
- `o_parity_err` out 1: parity mismatch; held until the next DONE.
- `o_break` out 1: all data samples, parity sample (if present) and first stop sample were 0; held until the next DONE.

## Operation
- **Input synchroniser:** 2-flop, reset value 1. A third flop feeds the edge detector: negedge = prev & ~cur.
- **Definitions:**
  - MID = (TICKS_PER_BIT-1)/2.
  - V = MAJORITY.
  - P = 1 if parity is active, else 0.
  - Sampled bit = majority of the synchronised line at strobe-2, strobe-1 and strobe (MAJORITY=1), or the line at strobe (MAJORITY=0).
- **States:** IDLE, START, DATA, PARITY, STOP, DONE.
- **IDLE:**
  - Tick counter = 0, bit counter = 0.
  - On negedge && `i_enable`, go to START.
- **START:**
  - Counter increments from 0; strobe at counter == MID+V, where the counter clears.
  - Sampled 1 → glitch, return to IDLE with no strobe and outputs unchanged.
  - Sampled 0 → DATA.
- **DATA:**
  - Strobe every TICKS_PER_BIT cycles; the counter wraps at TICKS_PER_BIT-1.
  - Each sample shifts into the MSB of an internal shift register.
  - After DATA_BITS strobes, go to PARITY if P, else STOP.
- **PARITY:**
  - One strobe; compare with the XOR of the data bits. Odd mode expects the total count of ones, parity bit included, to be odd.
  - Then STOP.
- **STOP:**
  - STOP_BITS strobes; any low sample sets the pending frame error.
  - After the last strobe, go to DONE. The receiver does not wait for the end of the stop bit.
- **DONE:**
  - One cycle. `o_rxdata` ← shift register; error flags ← pending values; `o_recvdata`=1.
  - Then IDLE.
- **Break line:** after a break the line is still low in IDLE, so no negedge occurs; the next frame requires the line to return high first.
- **`i_enable` low mid-frame:** the frame completes normally.
- **Reset mid-frame:** return to IDLE next cycle. `o_rxdata`=0, all flags=0, `o_recvdata`=0, `o_busy`=0, synchroniser=1.

## Timing
- Reset values: every output 0 except `o_rxdata`=0 (all bits).
- Pin-to-detect: a falling pin edge before rising edge n gives negedge high in cycle n+2.
- Let E = the cycle negedge is high in IDLE.
  - START is entered at E+1.
  - Start strobe at E+1+MID+V.
  - Bit k strobe (k=1..DATA_BITS+P+STOP_BITS) at E+1+MID+V+k·TICKS_PER_BIT.
  - `o_recvdata` at last strobe +1.
- Default 8N1, TICKS_PER_BIT=32, MAJORITY=1: `o_recvdata` at E+306.
- Back-to-back: IDLE is re-entered about TICKS_PER_BIT/2 before the nominal stop end, so a start bit that immediately follows is detected.
- `o_busy` is high from E+1 through DONE inclusive.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state and parity check are compiled in; `PARITY_MODE` is honoured.
- Undefined:
  - PARITY state is absent; P=0 regardless of `PARITY_MODE`.
  - `o_parity_err` is tied 0; a parity-bearing line is treated as an extra stop-bit period, so a received parity 0 raises `o_frame_err`.

## Test plan
- Reset, then 8N1 character 0xA5 at 32 ticks/bit → one `o_recvdata` pulse at E+306; `o_rxdata`=0xA5; all flags 0; `o_busy` 0 after.
- 2-cycle low glitch on an idle line → return to IDLE; no strobe; `o_rxdata` unchanged.
- `UART_RX_PARITY_EN`, PARITY_MODE=2, DATA_BITS=7, 0x41 with parity 0 then 0x41 with parity 1 → first frame `o_parity_err`=0, second =1, `o_rxdata`=0x41 both.
- STOP_BITS=2, second stop bit driven low → `o_frame_err`=1, data correct; line held low 20 bit-times → `o_break`=1 on that frame, then no further strobe until the line rises and a new start arrives.
- MAJORITY=1, single-cycle inverted spike on the data-bit-3 mid-point sample → `o_rxdata` still correct (0x3C).
- Reset asserted mid-DATA, then a clean 0x5A frame → no strobe for the aborted frame; next strobe carries 0x5A with flags 0.

Source files
------------

// File: rtl/uart_rx_frame_if.sv
// Receive-side result bundle of uart_rx_frame: registered character plus status.
// The receiver drives it through the master modport and the parser reads it through the slave modport.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] o_rxdata;
  logic                 o_recvdata;
  logic                 o_busy;
  logic                 o_frame_err;
  logic                 o_parity_err;
  logic                 o_break;

  modport master (
    output o_rxdata, o_recvdata, o_busy, o_frame_err, o_parity_err, o_break
  );

  modport slave (
    input o_rxdata, o_recvdata, o_busy, o_frame_err, o_parity_err, o_break
  );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receiver: 5..9 data bits, 1/2 stop bits, 3-sample majority vote, framing/parity/break flags.
// Parity checking is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_frame #(
  parameter int TICKS_PER_BIT      = 32,
  parameter int TICKS_PER_BIT_SIZE = 6,
  parameter int DATA_BITS          = 8,
  parameter int STOP_BITS          = 1,
  parameter int PARITY_MODE        = 0,
  parameter int MAJORITY           = 1
) (
  input  logic            i_clk,
  input  logic            reset,
  input  logic            i_enable,
  input  logic            i_din_priortobuffer,
  uart_rx_frame_if.master rx
);
  // state    | meaning
  // S_IDLE   | waiting for a falling edge while enabled
  // S_START  | timing to the start-bit centre, rejecting glitches
  // S_DATA   | sampling DATA_BITS bits, LSB first
  // S_PARITY | sampling and checking the parity bit
  // S_STOP   | sampling STOP_BITS stop bits
  // S_DONE   | one-cycle character hand-over

  localparam int MID = (TICKS_PER_BIT - 1) / 2;
  localparam logic [TICKS_PER_BIT_SIZE-1:0] START_TC = TICKS_PER_BIT_SIZE'(MID + MAJORITY);
  localparam logic [TICKS_PER_BIT_SIZE-1:0] BIT_TC   = TICKS_PER_BIT_SIZE'(TICKS_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic                          sync_meta, sync_line, sync_prev;
  logic [1:0]                    hist;
  logic [TICKS_PER_BIT_SIZE-1:0] tick_cnt;
  logic [3:0]                    bit_cnt;
  logic [DATA_BITS-1:0]          shreg;
  logic                          frame_pend, frame_nxt;
  logic                          par_pend, par_nxt;
  logic                          brk_pend, brk_nxt;
  logic                          fall, vote, strobe, load_out;

  assign fall = sync_prev & ~sync_line;
  // hist[0] is the line one cycle before the strobe, hist[1] two cycles before
  assign vote = (MAJORITY != 0)
              ? ((hist[1] & hist[0]) | (hist[1] & sync_line) | (hist[0] & sync_line))
              : sync_line;
  assign load_out = (state == S_STOP) && strobe && (bit_cnt == STOP_LAST);

  assign rx.o_busy     = (state != S_IDLE);
  assign rx.o_recvdata = (state == S_DONE);

  always_comb begin
    strobe = 1'b0;
    case (state)
      S_IDLE, S_DONE: strobe = 1'b0;
      S_START:        strobe = (tick_cnt == START_TC);
      default:        strobe = (tick_cnt == BIT_TC);
    endcase
  end

  always_comb begin
    state_nxt = state;
    frame_nxt = frame_pend;
    par_nxt   = par_pend;
    brk_nxt   = brk_pend;
    case (state)
      S_IDLE: if (fall && i_enable) state_nxt = S_START;
      S_START: if (strobe) begin
        if (vote) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_DATA;
          frame_nxt = 1'b0;
          par_nxt   = 1'b0;
          brk_nxt   = 1'b1;
        end
      end
      S_DATA: if (strobe) begin
        brk_nxt = brk_pend & ~vote;
        if (bit_cnt == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
`else
          state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (strobe) begin
        brk_nxt   = brk_pend & ~vote;
        // odd mode wants the total number of ones to be odd
        par_nxt   = (^shreg) ^ vote ^ (PARITY_MODE == 1);
        state_nxt = S_STOP;
      end
`endif
      S_STOP: if (strobe) begin
        if (!vote) frame_nxt = 1'b1;
        if (bit_cnt == 4'd0) brk_nxt = brk_pend & ~vote;
        if (bit_cnt == STOP_LAST) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      sync_meta       <= 1'b1;
      sync_line       <= 1'b1;
      sync_prev       <= 1'b1;
      hist            <= 2'b11;
      tick_cnt        <= '0;
      bit_cnt         <= '0;
      shreg           <= '0;
      frame_pend      <= 1'b0;
      par_pend        <= 1'b0;
      brk_pend        <= 1'b0;
      rx.o_rxdata     <= '0;
      rx.o_frame_err  <= 1'b0;
      rx.o_parity_err <= 1'b0;
      rx.o_break      <= 1'b0;
    end else begin
      sync_meta  <= i_din_priortobuffer;
      sync_line  <= sync_meta;
      sync_prev  <= sync_line;
      hist       <= {hist[0], sync_line};
      frame_pend <= frame_nxt;
      par_pend   <= par_nxt;
      brk_pend   <= brk_nxt;

      if (state == S_IDLE || state == S_DONE || strobe) tick_cnt <= '0;
      else                                              tick_cnt <= tick_cnt + 1'b1;

      if (state_nxt != state) bit_cnt <= '0;
      else if (strobe)        bit_cnt <= bit_cnt + 1'b1;

      if (state == S_DATA && strobe) shreg <= {vote, shreg[DATA_BITS-1:1]};

      if (load_out) begin
        rx.o_rxdata     <= shreg;
        rx.o_frame_err  <= frame_nxt;
        rx.o_parity_err <= par_nxt;
        rx.o_break      <= brk_nxt;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: three receiver configurations driven by directed serial frames.
// Expected characters are queued when a frame is sent and popped on each o_recvdata strobe.
module tb_uart_rx_frame;
  localparam int TPB_A = 32;
  localparam int TPB_B = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] line;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  logic [11:0] q_a[$];
  logic [11:0] q_b[$];
  logic [11:0] q_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_rx_frame_if #(.DATA_BITS(8)) if_a ();
  uart_rx_frame_if #(.DATA_BITS(7)) if_b ();
  uart_rx_frame_if #(.DATA_BITS(8)) if_c ();

  uart_rx_frame #(
    .TICKS_PER_BIT(TPB_A), .TICKS_PER_BIT_SIZE(6), .DATA_BITS(8),
    .STOP_BITS(1), .PARITY_MODE(0), .MAJORITY(1)
  ) dut_a (
    .i_clk(clk), .reset(reset), .i_enable(enable), .i_din_priortobuffer(line[0]), .rx(if_a)
  );

  uart_rx_frame #(
    .TICKS_PER_BIT(TPB_B), .TICKS_PER_BIT_SIZE(5), .DATA_BITS(7),
    .STOP_BITS(1), .PARITY_MODE(2), .MAJORITY(1)
  ) dut_b (
    .i_clk(clk), .reset(reset), .i_enable(enable), .i_din_priortobuffer(line[1]), .rx(if_b)
  );

  uart_rx_frame #(
    .TICKS_PER_BIT(TPB_B), .TICKS_PER_BIT_SIZE(5), .DATA_BITS(8),
    .STOP_BITS(2), .PARITY_MODE(0), .MAJORITY(1)
  ) dut_c (
    .i_clk(clk), .reset(reset), .i_enable(enable), .i_din_priortobuffer(line[2]), .rx(if_c)
  );

  function automatic logic [11:0] pk(input logic [8:0] d, input logic fe, input logic pe,
                                     input logic brk);
    return {brk, pe, fe, d};
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // bits[0] goes on the line first; spike inverts one cycle in the middle of that bit
  task automatic send(input int sel, input logic [31:0] bits, input int n, input int tpb,
                      input int spike);
    for (int i = 0; i < n; i++) begin
      if (i == spike) begin
        line[sel] = bits[i];
        repeat (tpb / 2) @(negedge clk);
        line[sel] = ~bits[i];
        @(negedge clk);
        line[sel] = bits[i];
        repeat (tpb / 2 - 1) @(negedge clk);
      end else begin
        line[sel] = bits[i];
        repeat (tpb) @(negedge clk);
      end
    end
    line[sel] = 1'b1;
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (if_a.o_recvdata === 1'b1) begin
      check("a_strobe_expected", 12'(q_a.size() != 0), 12'd1);
      if (q_a.size() != 0)
        check("a_char", pk(9'(if_a.o_rxdata), if_a.o_frame_err, if_a.o_parity_err, if_a.o_break),
              q_a.pop_front());
    end
    if (if_b.o_recvdata === 1'b1) begin
      check("b_strobe_expected", 12'(q_b.size() != 0), 12'd1);
      if (q_b.size() != 0)
        check("b_char", pk(9'(if_b.o_rxdata), if_b.o_frame_err, if_b.o_parity_err, if_b.o_break),
              q_b.pop_front());
    end
    if (if_c.o_recvdata === 1'b1) begin
      check("c_strobe_expected", 12'(q_c.size() != 0), 12'd1);
      if (q_c.size() != 0)
        check("c_char", pk(9'(if_c.o_rxdata), if_c.o_frame_err, if_c.o_parity_err, if_c.o_break),
              q_c.pop_front());
    end
  end

  // busy rises at E+1, o_recvdata at E+306
  logic busy_a_q = 1'b0;
  int   rise_a = 0;
  always @(negedge clk) begin
    if (if_a.o_busy === 1'b1 && !busy_a_q) rise_a = cyc;
    if (if_a.o_recvdata === 1'b1) check("a_latency", 12'(cyc - rise_a), 12'd305);
    busy_a_q = (if_a.o_busy === 1'b1);
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    line   = 3'b111;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("a_reset_out", pk(9'(if_a.o_rxdata), if_a.o_frame_err, if_a.o_parity_err, if_a.o_break), 12'h0);
    check("a_reset_ctl", {10'd0, if_a.o_busy, if_a.o_recvdata}, 12'h0);
    check("c_reset_out", pk(9'(if_c.o_rxdata), if_c.o_frame_err, if_c.o_parity_err, if_c.o_break), 12'h0);

    // 8N1 0xA5
    q_a.push_back(pk(9'h0A5, 1'b0, 1'b0, 1'b0));
    send(0, {1'b1, 8'hA5, 1'b0}, 10, TPB_A, -1);
    repeat (40) @(negedge clk);
    check("a_busy_after", {11'd0, if_a.o_busy}, 12'h0);

    // 2-cycle glitch must be rejected
    line[0] = 1'b0;
    repeat (2) @(negedge clk);
    line[0] = 1'b1;
    repeat (80) @(negedge clk);
    check("a_glitch_hold", pk(9'(if_a.o_rxdata), if_a.o_frame_err, if_a.o_parity_err, if_a.o_break),
          pk(9'h0A5, 1'b0, 1'b0, 1'b0));
    check("a_glitch_idle", {11'd0, if_a.o_busy}, 12'h0);

    // single-cycle spike in the middle of data bit 3
    q_a.push_back(pk(9'h03C, 1'b0, 1'b0, 1'b0));
    send(0, {1'b1, 8'h3C, 1'b0}, 10, TPB_A, 4);
    repeat (40) @(negedge clk);

    // 7 data bits + even parity: correct then wrong parity bit
`ifdef UART_RX_PARITY_EN
    q_b.push_back(pk(9'h041, 1'b0, 1'b0, 1'b0));
    q_b.push_back(pk(9'h041, 1'b0, 1'b1, 1'b0));
`else
    q_b.push_back(pk(9'h041, 1'b1, 1'b0, 1'b0));
    q_b.push_back(pk(9'h041, 1'b0, 1'b0, 1'b0));
`endif
    send(1, {1'b1, 1'b0, 7'h41, 1'b0}, 10, TPB_B, -1);
    repeat (2 * TPB_B) @(negedge clk);
    send(1, {1'b1, 1'b1, 7'h41, 1'b0}, 10, TPB_B, -1);
    repeat (2 * TPB_B) @(negedge clk);

    // two stop bits, second one low
    q_c.push_back(pk(9'h096, 1'b1, 1'b0, 1'b0));
    send(2, {1'b0, 1'b1, 8'h96, 1'b0}, 11, TPB_B, -1);
    repeat (3 * TPB_B) @(negedge clk);

    // break: 20 bit-times low, then no further strobe until a new start
    q_c.push_back(pk(9'h000, 1'b1, 1'b0, 1'b1));
    line[2] = 1'b0;
    repeat (20 * TPB_B) @(negedge clk);
    check("c_break_flag", {11'd0, if_c.o_break}, 12'h1);
    line[2] = 1'b1;
    repeat (3 * TPB_B) @(negedge clk);
    q_c.push_back(pk(9'h0C3, 1'b0, 1'b0, 1'b0));
    send(2, {2'b11, 8'hC3, 1'b0}, 11, TPB_B, -1);
    repeat (3 * TPB_B) @(negedge clk);

    // reset in the middle of DATA, then a clean 0x5A
    send(0, {3'b101, 1'b0}, 4, TPB_A, -1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("a_midreset_out", pk(9'(if_a.o_rxdata), if_a.o_frame_err, if_a.o_parity_err, if_a.o_break), 12'h0);
    check("a_midreset_ctl", {10'd0, if_a.o_busy, if_a.o_recvdata}, 12'h0);
    repeat (12 * TPB_A) @(negedge clk);
    q_a.push_back(pk(9'h05A, 1'b0, 1'b0, 1'b0));
    send(0, {1'b1, 8'h5A, 1'b0}, 10, TPB_A, -1);
    repeat (40) @(negedge clk);

    check("a_drained", 12'(q_a.size()), 12'd0);
    check("b_drained", 12'(q_b.size()), 12'd0);
    check("c_drained", 12'(q_c.size()), 12'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
